// File: rtl/exp_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : exp_shift_add
// Purpose  : Iterative shift-and-add exponential (antilog) unit. Computes
//            xf = e^y0 for an unsigned Q4.10 argument by multiplicative
//            normalisation, one step per clock. It is the inverse companion
//            of the 14-bit logarithm block and shares its start/done
//            handshake on the same clock domain.
//
// Ports    : clk    in   1   system clock, rising edge
//            reset  in   1   asynchronous reset, active low
//            start  in   1   one-cycle request, samples y0
//            y0     in  14   argument, unsigned Q4.10
//            xf     out 14   result e^y0, unsigned Q4.10
//            yf     out 14   final residual, Q4.10
//            busy   out  1   high while the iteration runs
//            done   out  1   one-cycle pulse when xf/yf are valid
//            ovf    out  1   last accepted y0 saturated the result
//
// Params   : ITER   number of fractional steps i = 1..ITER (legal 1..9)
//
// Options  : EXP_SHIFT_ADD_RESTART_EN - when defined, start during the
//            iteration aborts the run and restarts it with the new y0.
//            When undefined, start is ignored outside IDLE.
//
// Revision : 1.0  initial release
// ============================================================================
module exp_shift_add #(
  parameter int ITER = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] y0,
  output logic [13:0] xf,
  output logic [13:0] yf,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INT  = 2'd1,
    S_FRAC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [13:0] C_ONE      = 14'd1024;   // 1.0 in Q4.10
  localparam logic [13:0] C_LN2      = 14'd709;    // ln2 in Q4.10
  localparam logic [13:0] C_SAT_LIM  = 14'd2836;   // 4*ln2: e^y0 >= 16.0
  localparam logic [13:0] C_SAT_VAL  = 14'h3FFF;
  localparam logic [3:0]  C_LAST_INT = 4'd2;       // integer steps use cnt 0..2
  localparam logic [3:0]  C_ITER     = 4'(ITER);

  // ln(1 + 2^-i) in Q4.10, truncated. Index 0 is never used in FRAC.
  function automatic logic [13:0] frac_const(input logic [3:0] idx);
    logic [13:0] t;
    case (idx)
      4'd1:    t = 14'd415;
      4'd2:    t = 14'd228;
      4'd3:    t = 14'd120;
      4'd4:    t = 14'd62;
      4'd5:    t = 14'd31;
      4'd6:    t = 14'd15;
      4'd7:    t = 14'd7;
      4'd8:    t = 14'd3;
      4'd9:    t = 14'd1;
      default: t = 14'd0;
    endcase
    return t;
  endfunction

  state_t      state_q, state_d;
  logic [13:0] x_q, x_d;
  logic [13:0] y_q, y_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] xf_q, xf_d;
  logic [13:0] yf_q, yf_d;
  logic        ovf_q, ovf_d;

  logic        w_can_accept;
  logic        w_accept;
  logic [13:0] w_t;

  // Which states may take a new request.
`ifdef EXP_SHIFT_ADD_RESTART_EN
  assign w_can_accept = (state_q == S_IDLE) || (state_q == S_INT) ||
                        (state_q == S_FRAC);
`else
  assign w_can_accept = (state_q == S_IDLE);
`endif

  assign w_accept = start && w_can_accept;

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      xf_q    <= '0;
      yf_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      xf_q    <= xf_d;
      yf_q    <= yf_d;
      ovf_q   <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    xf_d    = xf_q;
    yf_d    = yf_q;
    ovf_d   = ovf_q;
    w_t     = frac_const(cnt_q);

    case (state_q)
      S_IDLE: begin
        // Request handling is done below, shared with the restart path.
      end

      S_INT: begin
        // Pull out whole factors of 2 first; three steps cover y0 < 4*ln2.
        if (y_q >= C_LN2) begin
          y_d = y_q - C_LN2;
          x_d = x_q << 1;
        end
        if (cnt_q == C_LAST_INT) begin
          state_d = S_FRAC;
          cnt_d   = 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_FRAC: begin
        // Multiply x by (1 + 2^-i) whenever ln(1 + 2^-i) still fits in y.
        // The argument range bounds x below 2^14, so no guard bits.
        if (y_q >= w_t) begin
          y_d = y_q - w_t;
          x_d = x_q + (x_q >> cnt_q);
        end
        if (cnt_q == C_ITER) begin
          xf_d    = x_d;
          yf_d    = y_d;
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fresh request overrides whatever the step above produced, which is
    // how a restart discards the partial result of the aborted run.
    if (w_accept) begin
      cnt_d = 4'd0;
      if (y0 >= C_SAT_LIM) begin
        xf_d    = C_SAT_VAL;
        yf_d    = y0;
        ovf_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        x_d     = C_ONE;
        y_d     = y0;
        ovf_d   = 1'b0;
        state_d = S_INT;
      end
    end
  end

  assign busy = (state_q == S_INT) || (state_q == S_FRAC);
  assign done = (state_q == S_DONE);
  assign xf   = xf_q;
  assign yf   = yf_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire
